fp_minmax_scanner: RTL and testbench

FP_MINMAX_SCANNER -- requirements
Module: fp_minmax_scanner

---
 rtl/fp_minmax_scanner.sv | 148 ++++++++++++++
 tb/tb_fp_minmax_scanner.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_minmax_scanner.sv
// Frame scanner tracking the running maximum and minimum of 13-bit
// sign/exponent/mantissa samples with a single time-shared comparator.

module FloatingPoint_comp (
   input  logic [12:0] A,
   input  logic [12:0] B,
   output logic        gt,
   output logic        lt,
   output logic        eq
);

   logic signed [12:0] key_a;
   logic signed [12:0] key_b;

   // Sign-magnitude to two's-complement ordering key; -0 and +0 map to the same key.
   function automatic logic signed [12:0] to_key(input logic [12:0] v);
      logic signed [12:0] mag;
      mag = signed'({1'b0, v[11:0]});
      return v[12] ? -mag : mag;
   endfunction

   always_comb begin
      key_a = to_key(A);
      key_b = to_key(B);
      gt    = key_a > key_b;
      lt    = key_a < key_b;
      eq    = key_a == key_b;
   end

endmodule

module fp_minmax_scanner #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [12:0]      in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [12:0]      max_val,
   output logic [12:0]      min_val,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {IDLE, WAIT_IN, CMP_MAX, CMP_MIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [12:0]       sample_q, sample_d;
   logic              last_q, last_d;
   logic [12:0]       max_q, max_d;
   logic [12:0]       min_q, min_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [12:0]       cmp_b;
   logic              cmp_gt, cmp_lt, cmp_eq;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   FloatingPoint_comp u_cmp (
      .A  (sample_q),
      .B  (cmp_b),
      .gt (cmp_gt),
      .lt (cmp_lt),
      .eq (cmp_eq)
   );

   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      last_d   = last_q;
      max_d    = max_q;
      min_d    = min_q;
      count_d  = count_q;
      cmp_b    = max_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT_IN;
               count_d = '0;
               max_d   = '0;
               min_d   = '0;
            end
         end
         WAIT_IN: begin
            if (in_valid) begin
               sample_d = in_data;
               last_d   = in_last;
               count_d  = sat_inc(count_q);
               // The first sample seeds both extremes and needs no comparison.
               if (count_q == '0) begin
                  max_d   = in_data;
                  min_d   = in_data;
                  state_d = in_last ? DONE : WAIT_IN;
               end else begin
                  state_d = CMP_MAX;
               end
            end
         end
         CMP_MAX: begin
            if (cmp_gt) max_d = sample_q;
            state_d = CMP_MIN;
         end
         CMP_MIN: begin
            cmp_b = min_q;
            if (cmp_lt) min_d = sample_q;
            state_d = last_q ? DONE : WAIT_IN;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         sample_q <= '0;
         last_q   <= 1'b0;
         max_q    <= '0;
         min_q    <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         last_q   <= last_d;
         max_q    <= max_d;
         min_q    <= min_d;
         count_q  <= count_d;
      end
   end

   assign in_ready = (state_q == WAIT_IN);
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign max_val  = max_q;
   assign min_val  = min_q;
   assign count    = count_q;

endmodule

// File: tb/tb_fp_minmax_scanner.sv
// Directed bench for fp_minmax_scanner; a CNT_W=2 copy shares the stimulus for saturation.

module tb_fp_minmax_scanner;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [12:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;

   logic        in_ready, busy, done;
   logic [12:0] max_val, min_val;
   logic [7:0]  count;

   logic        in_ready2, busy2, done2;
   logic [12:0] max_val2, min_val2;
   logic [1:0]  count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_minmax_scanner #(.CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .max_val(max_val), .min_val(min_val), .count(count),
      .busy(busy), .done(done)
   );

   fp_minmax_scanner #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready2),
      .max_val(max_val2), .min_val(min_val2), .count(count2),
      .busy(busy2), .done(done2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offers one sample and returns just after the edge that accepted it.
   task automatic feed(input logic [12:0] d, input logic last);
      int n;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL feed_ready_timeout data=%h in_ready=%0b required 1", d, in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      logic bad;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 ||
             max_val !== 13'h0 || min_val !== 13'h0 || count !== 8'h0) bad = 1'b1;
         tick();
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_idle busy=%0b rdy=%0b done=%0b max=%h min=%h cnt=%0d required all 0",
                  busy, in_ready, done, max_val, min_val, count);
      end
   endtask

   task automatic test_three_sample();
      int n;
      do_start();
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_wait_in busy=%0b rdy=%0b required 1 1", busy, in_ready);
      end
      feed(13'h0300, 1'b0);
      feed(13'h1280, 1'b0);
      feed(13'h0501, 1'b1);
      wait_done(n);
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL three_latency edges_after_accept=%0d required 2", n);
      end
      checks++;
      if (max_val !== 13'h0501 || min_val !== 13'h1280 || count !== 8'd3) begin
         errors++;
         $display("FAIL three_result max=%h min=%h cnt=%0d required 0501 1280 3",
                  max_val, min_val, count);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL three_done_pulse done=%0b busy=%0b required 0 0", done, busy);
      end
   endtask

   task automatic test_single_sample();
      int n;
      do_start();
      feed(13'h1F00, 1'b1);
      wait_done(n);
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL single_latency edges_after_accept=%0d required 0", n);
      end
      checks++;
      if (max_val !== 13'h1F00 || min_val !== 13'h1F00 || count !== 8'd1) begin
         errors++;
         $display("FAIL single_result max=%h min=%h cnt=%0d required 1F00 1F00 1",
                  max_val, min_val, count);
      end
      // Inputs outside WAIT_IN must not disturb the held results.
      in_valid = 1'b1;
      in_data  = 13'h0FFF;
      for (int i = 0; i < 4; i++) tick();
      in_valid = 1'b0;
      checks++;
      if (max_val !== 13'h1F00 || min_val !== 13'h1F00 || count !== 8'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_hold max=%h min=%h cnt=%0d busy=%0b required 1F00 1F00 1 0",
                  max_val, min_val, count, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] vec [3];
      int acc_cyc [3];
      int accepts, idx, k, extra;
      logic rdy, done_seen;
      vec[0] = 13'h0420; vec[1] = 13'h0420; vec[2] = 13'h0100;
      do_start();
      idx = 0; accepts = 0; k = 0; done_seen = 1'b0; extra = 0;
      in_valid = 1'b1;
      in_data  = vec[0];
      in_last  = 1'b0;
      while (!done_seen && k < 40) begin
         rdy = in_ready;
         tick();
         k++;
         if (rdy) begin
            if (accepts < 3) acc_cyc[accepts] = k;
            accepts++;
            idx++;
            if (idx < 3) begin
               in_data = vec[idx];
               in_last = (idx == 2);
            end
         end
         if (done) done_seen = 1'b1;
      end
      for (int i = 0; i < 5; i++) begin
         if (in_ready) extra++;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (accepts !== 3 || extra !== 0 || !done_seen) begin
         errors++;
         $display("FAIL b2b_accepts accepts=%0d extra_ready=%0d done=%0b required 3 0 1",
                  accepts, extra, done_seen);
      end
      checks++;
      if (accepts == 3 && (acc_cyc[1] - acc_cyc[0] !== 1 || acc_cyc[2] - acc_cyc[1] !== 3)) begin
         errors++;
         $display("FAIL b2b_gaps gap1=%0d gap2=%0d required 1 3",
                  acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
      checks++;
      if (max_val !== 13'h0420 || min_val !== 13'h0100 || count !== 8'd3) begin
         errors++;
         $display("FAIL b2b_result max=%h min=%h cnt=%0d required 0420 0100 3",
                  max_val, min_val, count);
      end
   endtask

   task automatic test_start_busy_and_abort();
      int n;
      logic saw_done, bad;
      do_start();
      feed(13'h0200, 1'b0);
      feed(13'h0100, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || count !== 8'd2) begin
         errors++;
         $display("FAIL start_ignored busy=%0b rdy=%0b cnt=%0d required 1 0 2", busy, in_ready, count);
      end
      feed(13'h0700, 1'b1);
      wait_done(n);
      checks++;
      if (n !== 2 || max_val !== 13'h0700 || min_val !== 13'h0100 || count !== 8'd3) begin
         errors++;
         $display("FAIL busy_frame lat=%0d max=%h min=%h cnt=%0d required 2 0700 0100 3",
                  n, max_val, min_val, count);
      end
      tick();
      // Abort a frame in CMP_MAX with reset.
      do_start();
      feed(13'h0300, 1'b0);
      feed(13'h0400, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || max_val !== 13'h0 || min_val !== 13'h0 || count !== 8'd0) begin
         errors++;
         $display("FAIL abort_state busy=%0b rdy=%0b max=%h min=%h cnt=%0d required 0 0 0 0 0",
                  busy, in_ready, max_val, min_val, count);
      end
      saw_done = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (done) saw_done = 1'b1;
         if (busy) bad = 1'b1;
         tick();
      end
      checks++;
      if (saw_done || bad) begin
         errors++;
         $display("FAIL abort_no_done done_seen=%0b busy_seen=%0b required 0 0", saw_done, bad);
      end
      do_start();
      feed(13'h1100, 1'b0);
      feed(13'h0001, 1'b1);
      wait_done(n);
      checks++;
      if (n !== 2 || max_val !== 13'h0001 || min_val !== 13'h1100 || count !== 8'd2) begin
         errors++;
         $display("FAIL after_abort lat=%0d max=%h min=%h cnt=%0d required 2 0001 1100 2",
                  n, max_val, min_val, count);
      end
      tick();
   endtask

   task automatic test_saturation();
      int n;
      do_start();
      feed(13'h0310, 1'b0);
      feed(13'h1010, 1'b0);
      feed(13'h0800, 1'b0);
      feed(13'h1300, 1'b0);
      feed(13'h0050, 1'b1);
      wait_done(n);
      checks++;
      if (n !== 2 || done2 !== 1'b1) begin
         errors++;
         $display("FAIL sat_latency lat=%0d done2=%0b required 2 1", n, done2);
      end
      checks++;
      if (count2 !== 2'd3 || max_val2 !== 13'h0800 || min_val2 !== 13'h1300) begin
         errors++;
         $display("FAIL sat_narrow cnt=%0d max=%h min=%h required 3 0800 1300",
                  count2, max_val2, min_val2);
      end
      checks++;
      if (count !== 8'd5 || max_val !== 13'h0800 || min_val !== 13'h1300) begin
         errors++;
         $display("FAIL sat_wide cnt=%0d max=%h min=%h required 5 0800 1300",
                  count, max_val, min_val);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_three_sample();
      test_single_sample();
      test_back_to_back();
      test_start_busy_and_abort();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
